// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor and its companion cells.
// FSM state encoding and the default operand width live here.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
// Reusable by any bit-serial arithmetic block.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - bin LSB first over WIDTH cycles.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    sub_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic            br_q, br_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cell_d, cell_bout;
    logic            cnt_last;
    logic            accept;

    full_subtractor_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign cnt_last = (cnt_q == CNT_LAST);
    assign accept   = (state_q == ST_IDLE) && in_valid;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Result fills from the MSB side so bit 0 lands last in position 0.
                res_d = {cell_d, res_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = cell_bout;
                if (cnt_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign diff       = res_q;
    assign borrow_out = br_q;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end
        // The last cell output is the result sign bit.
        if (state_q == ST_SHIFT && cnt_last) begin
            ovf_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign overflow      = 1'b0;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: accepts two WIDTH-bit operands plus a borrow-in over a valid/ready handshake. It computes `a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It returns the difference, borrow-out and signed-overflow flag over a second valid/ready handshake. It is the inverse-direction companion to the combinational full-adder datapath and serves area-constrained arithmetic paths where WIDTH-cycle latency is acceptable.

## Interface
- `WIDTH`, 8: operand and result width in bits; minimum 2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: operands `a`, `b`, `bin` valid.
- `in_ready` out 1: block can accept operands; high only in IDLE.
- `a` in WIDTH: minuend.
- `b` in WIDTH: subtrahend.
- `bin` in 1: borrow-in.
- `out_valid` out 1: result valid; high only in DONE.
- `out_ready` in 1: consumer accepts result.
- `diff` out WIDTH: `a - b - bin` mod 2^WIDTH.
- `borrow_out` out 1: unsigned borrow, set when `a < b + bin`.
- `overflow` out 1: signed overflow (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE:** `in_ready`=1. On `in_valid && in_ready`:
  - capture `a` and `b` into shift registers;
  - load the borrow flop with `bin`;
  - capture `a[WIDTH-1]` and `b[WIDTH-1]` for overflow;
  - clear the bit counter;
  - go to SHIFT.
- **SHIFT:** each cycle the cell computes on the operand LSBs and borrow flop:
  - `d = a0 ^ b0 ^ br`;
  - `bo = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - `d` shifts into the result register from the MSB side; the operand registers shift right; the borrow flop takes `bo`; the counter increments.
  - When the counter reaches WIDTH-1, go to DONE on that edge.
- **DONE:** `out_valid`=1. `diff`, `borrow_out` (final borrow flop) and `overflow` are held stable until `out_ready`=1, then return to IDLE.
- `in_valid` is ignored outside IDLE. Operands are not re-sampled during SHIFT; changing input pins mid-operation has no effect.
- Counter width is `$clog2(WIDTH)`; the terminal compare is against WIDTH-1, with no wrap past it.
- `diff`, `borrow_out` and `overflow` outputs are registered. Their values outside DONE are don't-care to consumers, but they must not glitch while `out_valid`=1.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - state IDLE;
  - `in_ready`=1, `out_valid`=0;
  - `diff`=0, `borrow_out`=0, `overflow`=0;
  - counter, shift registers and borrow flop cleared.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. The result is lost and no `out_valid` is emitted.
- Latency: if operands are accepted on edge E0, `out_valid` rises after edge E0+WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles.
  - DONE with `out_ready`=1 returns to IDLE next edge.
  - IDLE accepts on the following edge at the earliest.
  - There is no same-cycle result-out/operand-in overlap.
- `out_ready` may be held high permanently; DONE then lasts exactly one cycle.
- `in_ready` and `out_valid` are decoded from registered state, so there are no combinational paths from `in_valid` or `out_ready`.

## Configuration
- Macro: `SERIAL_SUBTRACTOR_OVERFLOW_EN`.
- Defined: `overflow` = `(a_msb != b_msb) && (diff[WIDTH-1] != a_msb)`, registered at the transition into DONE.
- Undefined:
  - the MSB capture flops and overflow logic are not compiled;
  - `overflow` is tied to 0;
  - the port list is unchanged.

## Structure
- Shared package `serial_subtractor_pkg` holds:
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - the default WIDTH constant.
- Sub-module `full_subtractor_cell`: combinational, ports `a`, `b`, `bin` → `d`, `bout`. It is instantiated once inside the SHIFT datapath and is reusable by the team's other serial arithmetic blocks.

## Test plan
All scenarios use WIDTH=8.
- 8'd5 − 8'd3, `bin`=0 → `diff`=8'h02, `borrow_out`=0, `overflow`=0; `out_valid` exactly 8 cycles after the accept edge.
- 8'h00 − 8'h01, `bin`=0 → `diff`=8'hFF, `borrow_out`=1, `overflow`=0.
- 8'h80 − 8'h01, `bin`=0 → `diff`=8'h7F, `borrow_out`=0; `overflow`=1 with the macro defined, 0 without.
- 8'h10 − 8'h0F, `bin`=1 → `diff`=8'h00, `borrow_out`=0; 8'h00 − 8'h00, `bin`=1 → 8'hFF, `borrow_out`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands → outputs stable, `in_ready`=0, new operands ignored; `out_ready`=1 → IDLE next edge.
- Assert `rst_n`=0 three cycles into SHIFT → `out_valid`=0 and `diff`=0 immediately; after release, `in_ready`=1, and 8'd200 − 8'd100 yields 8'd100, `borrow_out`=0.
